// File: rtl/addsub_mul_pipe.sv
// (a +/- b) * c in a 2-stage valid/ready pipeline; optional gated data clocks via ADDSUB_MUL_ICG_EN.
// Latency: accept in cycle N -> result valid in cycle N+2; one beat per cycle when unstalled.
// Backpressure: out_ready low freezes stage 2, then stage 1; in_ready drops only when both are full.
module addsub_mul_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     c,
   input  logic                 s,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   d,
   output logic [CNT_W-1:0]     op_count,
   output logic                 busy
);

   localparam int RW = 2 * WIDTH;

   logic              s1_valid_q, s1_valid_d;
   logic              s2_valid_q, s2_valid_d;
   logic [RW-1:0]     sum_q, sum_d;
   logic [WIDTH-1:0]  c_q, c_d;
   logic [RW-1:0]     d_q, d_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic              accept;
   logic              s2_adv;
   logic              consume;
   logic [RW-1:0]     a_ext;
   logic [RW-1:0]     b_ext;
   logic [RW-1:0]     c_ext;

   always_comb begin
      s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
      in_ready = ~s1_valid_q | s2_adv;
      accept   = in_valid & in_ready;
      consume  = s2_valid_q & out_ready;

      s1_valid_d = s1_valid_q;
      if (accept)
         s1_valid_d = 1'b1;
      else if (s2_adv)
         s1_valid_d = 1'b0;

      s2_valid_d = s2_valid_q;
      if (s2_adv)
         s2_valid_d = 1'b1;
      else if (consume)
         s2_valid_d = 1'b0;

      op_count_d = op_count_q;
      if (consume)
         op_count_d = op_count_q + 1'b1;

      // Zero-extend before the subtract so a < b wraps modulo 2^RW.
      a_ext = {{WIDTH{1'b0}}, a};
      b_ext = {{WIDTH{1'b0}}, b};
      c_ext = {{WIDTH{1'b0}}, c_q};
      sum_d = s ? (a_ext + b_ext) : (a_ext - b_ext);
      c_d   = c;
      d_d   = sum_q * c_ext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         op_count_q <= op_count_d;
      end
   end

`ifdef ADDSUB_MUL_ICG_EN
   logic en1_lat, en2_lat;
   logic gclk1, gclk2;

   // Enables are captured while clk is low so the gated clock cannot glitch high.
   always_latch begin
      if (!clk) begin
         en1_lat <= accept;
         en2_lat <= s2_adv;
      end
   end

   assign gclk1 = clk & en1_lat;
   assign gclk2 = clk & en2_lat;

   always_ff @(posedge gclk1 or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
         c_q   <= '0;
      end else begin
         sum_q <= sum_d;
         c_q   <= c_d;
      end
   end

   always_ff @(posedge gclk2 or posedge rst) begin
      if (rst)
         d_q <= '0;
      else
         d_q <= d_d;
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
         c_q   <= '0;
      end else if (accept) begin
         sum_q <= sum_d;
         c_q   <= c_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         d_q <= '0;
      else if (s2_adv)
         d_q <= d_d;
   end
`endif

   assign out_valid = s2_valid_q;
   assign d         = d_q;
   assign op_count  = op_count_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_addsub_mul_pipe.sv
// Directed and random checks of addsub_mul_pipe: latency, arithmetic wrap, back-to-back, stall, reset.
module tb_addsub_mul_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b, c;
   logic        s;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] d;
   logic [15:0] op_count;
   logic        busy;

   int total;
   int bad;

   addsub_mul_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .s(s),
      .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .op_count(op_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model(input logic [7:0] fa, input logic [7:0] fb,
                                         input logic [7:0] fc, input logic fs);
      logic [15:0] t;
      t = fs ? ({8'd0, fa} + {8'd0, fb}) : ({8'd0, fa} - {8'd0, fb});
      return t * {8'd0, fc};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      tick;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
      total++; if (d !== 16'd0) begin bad++; $display("FAIL reset_d: got %0d want 0", d); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_latency;
      tick;
      a = 8'd200; b = 8'd100; c = 8'd3; s = 1'b1; in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got out_valid=%b want 0 at N+1", out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy: got %b want 1", busy); end
      tick;
      total++; if (out_valid !== 1'b1 || d !== 16'd900) begin
         bad++; $display("FAIL lat_result: got vld=%b d=%0d want vld=1 d=900", out_valid, d);
      end
      tick;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain: got out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_sub_and_max;
      logic [7:0]  ta [2];
      logic [7:0]  tb_ [2];
      logic [7:0]  tc [2];
      logic        ts [2];
      logic [15:0] te [2];
      ta = '{8'd100, 8'd255}; tb_ = '{8'd200, 8'd0}; tc = '{8'd3, 8'd255};
      ts = '{1'b0, 1'b1};     te = '{16'd65236, 16'd65025};
      for (int i = 0; i < 2; i++) begin
         tick;
         a = ta[i]; b = tb_[i]; c = tc[i]; s = ts[i]; in_valid = 1'b1;
         tick;
         in_valid = 1'b0;
         tick;
         total++; if (out_valid !== 1'b1 || d !== te[i]) begin
            bad++; $display("FAIL vec%0d: got vld=%b d=%0d want vld=1 d=%0d", i, out_valid, d, te[i]);
         end
      end
      tick;
      total++; if (op_count !== 16'd3) begin bad++; $display("FAIL vec_op_count: got %0d want 3", op_count); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] exp_q [$];
      int sent, got, gaps;
      sent = 0; got = 0; gaps = 0;
      do_reset;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 400 && got < 200; cyc++) begin
         tick;
         if (out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_extra: got d=%0d want no result", d);
            end else begin
               if (d !== exp_q[0]) begin
                  bad++; $display("FAIL b2b_data%0d: got %0d want %0d", got, d, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            got++;
         end else if (got > 0 && got < 200) begin
            gaps++;
         end
         if (sent < 200) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); s = 1'($urandom);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, c, s));
            sent++;
         end
      end
      in_valid = 1'b0;
      total++; if (got !== 200) begin bad++; $display("FAIL b2b_count: got %0d want 200", got); end
      total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
      tick;
      total++; if (op_count !== 16'd200) begin bad++; $display("FAIL b2b_op_count: got %0d want 200", op_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_stall;
      logic [7:0]  va [3];
      logic [7:0]  vb [3];
      logic [7:0]  vc [3];
      logic        vs [3];
      logic [15:0] ve [3];
      int idx, got;
      va = '{8'd10, 8'd3, 8'd50};  vb = '{8'd5, 8'd7, 8'd50};
      vc = '{8'd2, 8'd10, 8'd200}; vs = '{1'b1, 1'b0, 1'b1};
      ve = '{16'd30, 16'd65496, 16'd20000};
      idx = 0; got = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         tick;
         if (cyc >= 2) begin
            total++; if (out_valid !== 1'b1 || d !== ve[0]) begin
               bad++; $display("FAIL stall_frozen%0d: got vld=%b d=%0d want vld=1 d=%0d", cyc, out_valid, d, ve[0]);
            end
         end
         a = va[idx]; b = vb[idx]; c = vc[idx]; s = vs[idx]; in_valid = 1'b1;
         #1;
         if (in_ready) idx++;
      end
      total++; if (idx !== 2) begin bad++; $display("FAIL stall_accepted: got %0d want 2", idx); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got in_ready=%b want 1", in_ready); end
      if (in_ready) idx++;
      got = 1;
      for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
         tick;
         if (out_valid === 1'b1) begin
            total++; if (d !== ve[got]) begin
               bad++; $display("FAIL stall_order%0d: got %0d want %0d", got, d, ve[got]);
            end
            got++;
         end
         if (idx < 3) begin
            a = va[idx]; b = vb[idx]; c = vc[idx]; s = vs[idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) idx++;
      end
      total++; if (got !== 3) begin bad++; $display("FAIL stall_results: got %0d want 3", got); end
      tick;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_dup: got out_valid=%b want 0", out_valid); end
      total++; if (op_count !== 16'd203) begin bad++; $display("FAIL stall_op_count: got %0d want 203", op_count); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      tick;
      a = 8'd10; b = 8'd5; c = 8'd2; s = 1'b1; in_valid = 1'b1;
      tick;
      a = 8'd20; b = 8'd1; c = 8'd2; s = 1'b1;
      tick;
      in_valid = 1'b0;
      total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
         bad++; $display("FAIL rmid_full: got busy=%b vld=%b want 1 1", busy, out_valid);
      end
      #1;
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      total++; if (op_count !== 16'd0) begin bad++; $display("FAIL rmid_op_count: got %0d want 0", op_count); end
      rst = 1'b0;
      out_ready = 1'b1;
      tick;
      a = 8'd7; b = 8'd3; c = 8'd4; s = 1'b0; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale: got out_valid=%b want 0", out_valid); end
      tick;
      total++; if (out_valid !== 1'b1 || d !== 16'd16) begin
         bad++; $display("FAIL rmid_result: got vld=%b d=%0d want vld=1 d=16", out_valid, d);
      end
      tick;
      total++; if (out_valid !== 1'b0 || op_count !== 16'd1) begin
         bad++; $display("FAIL rmid_after: got vld=%b cnt=%0d want vld=0 cnt=1", out_valid, op_count);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0; s = 1'b0;
      test_reset;
      test_latency;
      test_sub_and_max;
      test_back_to_back;
      test_stall;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
